// File: rtl/unified_line_mem_if.sv
// Line-request bus between the cache controller (master) and the unified
// main memory (slave). Both requests are levels that the master holds until
// rdy is seen high.
interface unified_line_mem_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 64
) ();
  logic              re;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              rdy;
  logic              busy;

  modport master (
    output re, we, addr, wr_data,
    input  rd_data, rdy, busy
  );

  modport slave (
    input  re, we, addr, wr_data,
    output rd_data, rdy, busy
  );
endinterface

// File: rtl/unified_line_mem.sv
// Unified main memory sitting below the I/D cache controller. It accepts one
// line read or write at a time, completes it a fixed LATENCY cycles later and
// then holds rdy high until the next request is accepted.
module unified_line_mem #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 64,
  parameter int LATENCY = 4
) (
  input  logic               clk,
  input  logic               rst,
  unified_line_mem_if.slave  bus
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("unified_line_mem: LATENCY must be in the range 1..15");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // The accepting edge already counts as the first latency cycle.
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              op_wr_q, op_wr_d;
  logic              rdy_q, rdy_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              mem_we;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Next-state logic: accept in IDLE, count down in BUSY, commit at zero.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    op_wr_d   = op_wr_q;
    rdy_d     = rdy_q;
    rd_data_d = rd_data_q;
    mem_we    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.re || bus.we) begin
          // A simultaneous re&we is a write; the read is dropped.
          addr_d  = bus.addr;
          wdata_d = bus.wr_data;
          op_wr_d = bus.we;
          cnt_d   = CNT_INIT;
          rdy_d   = 1'b0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (op_wr_q) begin
            mem_we = 1'b1;
          end else begin
            rd_data_d = mem[addr_q];
          end
          rdy_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and captured-request registers, cleared by the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      op_wr_q   <= 1'b0;
      rdy_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      op_wr_q   <= op_wr_d;
      rdy_q     <= rdy_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Line array write port; a reset mid-write leaves the array untouched
  // because mem_we is only raised from the BUSY state.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; clearing it would turn a RAM into
    // flip-flops, and its contents are defined only by writes.
    if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign bus.rdy     = rdy_q;
  assign bus.busy    = (state_q == ST_BUSY);
  assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_unified_line_mem.sv
// Self-checking bench for unified_line_mem: directed scenarios plus a
// randomized mix of reads, writes and re&we requests, checked against a
// line-level model (associative array of written lines).
module tb_unified_line_mem;

  localparam int ADDR_W  = 14;
  localparam int DATA_W  = 64;
  localparam int LATENCY = 4;
  localparam int TIMEOUT = 64;

  logic clk;
  logic rst;

  unified_line_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  unified_line_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LATENCY(LATENCY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: contents of every line written so far, plus the value
  // rd_data must show and the level rdy must hold between transactions.
  logic [DATA_W-1:0] model [int];
  logic [DATA_W-1:0] exp_rd;
  logic              exp_rdy;
  int                written [$];

  // Apply reset asynchronously, check outputs while it is held, release.
  task automatic do_reset();
    rst = 1'b1;
    bus.re = 1'b0;
    bus.we = 1'b0;
    #2;
    checks++; if (bus.rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b expected 0", bus.rdy); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
    checks++; if (bus.rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h expected 0", bus.rd_data); end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rd  = '0;
    exp_rdy = 1'b0;
  endtask

  // Idle cycles with no request: outputs must hold their levels.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.rdy !== exp_rdy) begin errors++; $display("FAIL idle_rdy cyc %0d got %b expected %b", i, bus.rdy, exp_rdy); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy cyc %0d got %b expected 0", i, bus.busy); end
      checks++; if (bus.rd_data !== exp_rd) begin errors++; $display("FAIL idle_rd_data cyc %0d got %h expected %h", i, bus.rd_data, exp_rd); end
    end
  endtask

  // One request, entered and left at #1 after a rising edge. The request is
  // presented now and accepted at the next edge; completion must follow
  // exactly LATENCY edges later. With hold set, re/we stay asserted so the
  // caller can present the next request for back-to-back acceptance.
  task automatic transact(input bit r, input bit w, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input bit hold);
    int cycles;
    bus.re      = r;
    bus.we      = w;
    bus.addr    = a;
    bus.wr_data = d;
    @(posedge clk); #1;
    checks++; if (bus.rdy !== 1'b0) begin errors++; $display("FAIL accept_rdy addr %h got %b expected 0", a, bus.rdy); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL accept_busy addr %h got %b expected 1", a, bus.busy); end
    cycles = 0;
    while (bus.rdy !== 1'b1 && cycles < TIMEOUT) begin
      checks++; if (bus.rd_data !== exp_rd) begin errors++; $display("FAIL busy_rd_hold addr %h got %h expected %h", a, bus.rd_data, exp_rd); end
      @(posedge clk); #1;
      cycles++;
    end
    checks++; if (cycles != LATENCY) begin errors++; $display("FAIL latency addr %h got %0d expected %0d", a, cycles, LATENCY); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL done_busy addr %h got %b expected 0", a, bus.busy); end
    if (w) begin
      model[int'(a)] = d;
      written.push_back(int'(a));
    end else if (r) begin
      exp_rd = model[int'(a)];
    end
    exp_rdy = 1'b1;
    checks++; if (bus.rd_data !== exp_rd) begin errors++; $display("FAIL done_rd_data addr %h got %h expected %h", a, bus.rd_data, exp_rd); end
    if (!hold) begin
      bus.re = 1'b0;
      bus.we = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    idle(10);
  endtask

  task automatic test_write_read();
    transact(1'b0, 1'b1, 14'h0123, 64'hDEAD_BEEF_0123_4567, 1'b0);
    idle(3);
    transact(1'b1, 1'b0, 14'h0123, 64'h0, 1'b0);
    checks++; if (bus.rd_data !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("FAIL write_read got %h expected deadbeef01234567", bus.rd_data); end
    idle(2);
  endtask

  // Dirty-miss order: write-back, then the fill is presented in the rdy cycle.
  task automatic test_dirty_miss();
    logic [DATA_W-1:0] fill;
    fill = {$urandom, $urandom};
    transact(1'b0, 1'b1, 14'h0040, fill, 1'b0);
    idle(1);
    transact(1'b0, 1'b1, 14'h3F00, {$urandom, $urandom}, 1'b1);
    transact(1'b1, 1'b0, 14'h0040, 64'h0, 1'b0);
    checks++; if (bus.rd_data !== fill) begin errors++; $display("FAIL dirty_miss_fill got %h expected %h", bus.rd_data, fill); end
    idle(1);
  endtask

  task automatic test_re_we();
    transact(1'b1, 1'b1, 14'h0007, 64'h1, 1'b0);
    idle(1);
    transact(1'b1, 1'b0, 14'h0007, 64'h0, 1'b0);
    checks++; if (bus.rd_data !== 64'h1) begin errors++; $display("FAIL re_we_read got %h expected 1", bus.rd_data); end
  endtask

  task automatic test_reset_mid_write();
    logic [DATA_W-1:0] prior;
    prior = {$urandom, $urandom};
    transact(1'b0, 1'b1, 14'h0010, prior, 1'b0);
    bus.we      = 1'b1;
    bus.addr    = 14'h0010;
    bus.wr_data = 64'hFF;
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end
    bus.we = 1'b0;
    do_reset();
    transact(1'b1, 1'b0, 14'h0010, 64'h0, 1'b0);
    checks++; if (bus.rd_data !== prior) begin errors++; $display("FAIL reset_mid_write got %h expected %h", bus.rd_data, prior); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) begin
      transact(1'b0, 1'b1, 14'(i), {$urandom, $urandom}, 1'b0);
    end
    idle(1);
    for (int i = 1; i <= 4; i++) begin
      transact(1'b1, 1'b0, 14'(i), 64'h0, (i != 4));
    end
    idle(2);
  endtask

  task automatic test_random();
    int                op;
    logic [ADDR_W-1:0] a;
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 2);
      if (op == 0) begin
        a = 14'(written[$urandom_range(0, written.size() - 1)]);
        transact(1'b1, 1'b0, a, {$urandom, $urandom}, $urandom_range(0, 1) == 1);
      end else begin
        a = 14'($urandom_range(0, 2**ADDR_W - 1));
        transact(op == 2, 1'b1, a, {$urandom, $urandom}, $urandom_range(0, 1) == 1);
      end
      if (bus.re !== 1'b1 && bus.we !== 1'b1) begin
        idle($urandom_range(0, 2));
      end
    end
    bus.re = 1'b0;
    bus.we = 1'b0;
    idle(1);
  endtask

  initial begin
    rst         = 1'b1;
    bus.re      = 1'b0;
    bus.we      = 1'b0;
    bus.addr    = '0;
    bus.wr_data = '0;
    exp_rd      = '0;
    exp_rdy     = 1'b0;
    test_reset();
    test_write_read();
    test_dirty_miss();
    test_re_we();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
